lkt_engine: RTL and testbench

LKT_ENGINE -- requirements
Module: lkt_engine

---
 rtl/lkt_engine.sv | 156 +++++++++++++++
 tb/tb_lkt_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lkt_engine.sv
// Lookup-table engine: configurable slot table, per-entry round-robin choice,
// one-cycle read stage feeding a response FIFO with valid/ready handshakes.
module lkt_engine #(
    parameter int RESULT_WIDTH = 3,
    parameter int NUM_LOOKUPS  = 8,
    parameter int NUM_CHOICES  = 2,
    parameter int RSP_DEPTH    = 4,
    localparam int IW = (NUM_LOOKUPS > 1) ? $clog2(NUM_LOOKUPS) : 1,
    localparam int CW = (NUM_CHOICES > 1) ? $clog2(NUM_CHOICES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [IW-1:0]           cfg_idx,
    input  logic [CW-1:0]           cfg_choice,
    input  logic [RESULT_WIDTH-1:0] cfg_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [IW-1:0]           req_idx,
    input  logic                    req_mode,
    input  logic [CW-1:0]           req_choice,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [RESULT_WIDTH-1:0] rsp_data,
    output logic [CW-1:0]           rsp_choice,
    output logic                    rsp_miss,
    output logic [15:0]             miss_count
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int OW = $clog2(RSP_DEPTH + 1) + 1;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0] data;
        logic [CW-1:0]           choice;
        logic                    miss;
    } rsp_t;

    logic [RESULT_WIDTH-1:0] tbl_data [NUM_LOOKUPS][NUM_CHOICES];
    logic                    tbl_wr   [NUM_LOOKUPS][NUM_CHOICES];
    logic [CW-1:0]           rr_ptr   [NUM_LOOKUPS];

    logic          cfg_ok;
    logic          accept;
    logic          lk_idx_ok;
    logic          lk_ch_ok;
    logic          lk_hit;
    logic [CW-1:0] lk_choice;
    rsp_t          lk_rsp;

    logic          s1_valid;
    rsp_t          s1_rsp;

    rsp_t          fifo_mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          push;
    logic          pop;
    rsp_t          head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CW-1:0] rr_inc(input logic [CW-1:0] p);
        return (p == CW'(NUM_CHOICES - 1)) ? '0 : p + CW'(1);
    endfunction

    assign cfg_ok = cfg_we && (32'(cfg_idx) < NUM_LOOKUPS) && (32'(cfg_choice) < NUM_CHOICES);

    // Held low during reset so no request is accepted while state is being cleared.
    assign req_ready = !rst && ((count + OW'(s1_valid)) < OW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    // Table is read combinationally at accept, so a same-edge cfg write is not yet visible.
    always_comb begin
        lk_idx_ok = 32'(req_idx) < NUM_LOOKUPS;
        lk_choice = '0;
        if (lk_idx_ok) begin
            lk_choice = req_mode ? rr_ptr[req_idx] : req_choice;
        end
        lk_ch_ok      = 32'(lk_choice) < NUM_CHOICES;
        lk_hit        = lk_idx_ok && lk_ch_ok && tbl_wr[req_idx][lk_choice];
        lk_rsp.data   = lk_hit ? tbl_data[req_idx][lk_choice] : '0;
        lk_rsp.choice = lk_choice;
        lk_rsp.miss   = !lk_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOOKUPS; i++) begin
                rr_ptr[i] <= '0;
                for (int j = 0; j < NUM_CHOICES; j++) begin
                    tbl_data[i][j] <= '0;
                    tbl_wr[i][j]   <= 1'b0;
                end
            end
        end else begin
            if (cfg_ok) begin
                tbl_data[cfg_idx][cfg_choice] <= cfg_data;
                tbl_wr[cfg_idx][cfg_choice]   <= 1'b1;
            end
            if (accept && req_mode && lk_idx_ok) begin
                rr_ptr[req_idx] <= rr_inc(rr_ptr[req_idx]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_rsp     <= '0;
            miss_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_rsp <= lk_rsp;
                if (lk_rsp.miss && (miss_count != 16'hFFFF)) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end

    // Admission control guarantees room for the stage-1 entry, so push is unconditional.
    assign push = s1_valid;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= s1_rsp;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + OW'(push) - OW'(pop);
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign rsp_valid  = (count != '0);
    assign rsp_data   = rsp_valid ? head.data   : '0;
    assign rsp_choice = rsp_valid ? head.choice : '0;
    assign rsp_miss   = rsp_valid ? head.miss   : 1'b0;

endmodule

// File: tb/tb_lkt_engine.sv
// Directed bench for lkt_engine: vector table of single lookups plus
// sequences for same-cycle write, back-pressure, throughput and reset.
module tb_lkt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [0:0]  cfg_choice;
    logic [2:0]  cfg_data;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_idx;
    logic        req_mode;
    logic [0:0]  req_choice;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_data;
    logic [0:0]  rsp_choice;
    logic        rsp_miss;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    lkt_engine dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_choice(cfg_choice), .cfg_data(cfg_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_mode(req_mode), .req_choice(req_choice),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_choice(rsp_choice), .rsp_miss(rsp_miss),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr; int wi; int wc; int wd;
        int idx; int mode; int ch;
        int ed; int ec; int em; int emc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr_slot(input int i, input int c, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_choice = 1'(c); cfg_data = 3'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Presents one request (optionally with a simultaneous cfg write) and waits for its response.
    task automatic lookup(input int i, input int m, input int c,
                          input bit we, input int wi, input int wc, input int wd,
                          output int d, output int ch, output int ms, output int lat);
        int w;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_idx = 3'(i); req_mode = m[0]; req_choice = 1'(c);
        cfg_we = we; cfg_idx = 3'(wi); cfg_choice = 1'(wc); cfg_data = 3'(wd);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cfg_we = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        d = int'(rsp_data); ch = int'(rsp_choice); ms = int'(rsp_miss);
    endtask

    vec_t vecs[12];
    int   d, ch, ms, lat;
    int   acc_n, rsp_n, rdy_ok, stale;
    bit   acc;
    int   exp_q[6];
    int   bp_idx[5];
    int   bp_ch[5];

    initial begin
        // wr wi wc wd | idx mode ch | data choice miss miss_count
        vecs[0]  = '{1, 3, 1, 5,  3, 0, 1,  5, 1, 0, 0};
        vecs[1]  = '{1, 2, 0, 1,  2, 0, 0,  1, 0, 0, 0};
        vecs[2]  = '{1, 2, 1, 6,  2, 0, 1,  6, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,  2, 1, 0,  1, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0,  2, 1, 0,  6, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0,  2, 1, 0,  1, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,  2, 1, 0,  6, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1};
        vecs[8]  = '{0, 0, 0, 0,  7, 0, 1,  0, 1, 1, 2};
        vecs[9]  = '{0, 0, 0, 0,  3, 1, 0,  0, 0, 1, 3};
        vecs[10] = '{0, 0, 0, 0,  3, 1, 0,  5, 1, 0, 3};
        vecs[11] = '{1, 5, 1, 2,  5, 0, 1,  2, 1, 0, 3};

        rst = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_choice = '0; cfg_data = '0;
        req_valid = 1'b0; req_idx = '0; req_mode = 1'b0; req_choice = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_miss_count", int'(miss_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", int'(req_ready), 1);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].wr) wr_slot(vecs[v].wi, vecs[v].wc, vecs[v].wd);
            lookup(vecs[v].idx, vecs[v].mode, vecs[v].ch, 1'b0, 0, 0, 0, d, ch, ms, lat);
            chk($sformatf("vec%0d_data", v), d, vecs[v].ed);
            chk($sformatf("vec%0d_choice", v), ch, vecs[v].ec);
            chk($sformatf("vec%0d_miss", v), ms, vecs[v].em);
            chk($sformatf("vec%0d_latency", v), lat, 2);
            @(negedge clk);
            chk($sformatf("vec%0d_miss_count", v), int'(miss_count), vecs[v].emc);
        end

        // Same-cycle write and lookup of one slot returns the old contents.
        wr_slot(1, 0, 3);
        lookup(1, 0, 0, 1'b1, 1, 0, 7, d, ch, ms, lat);
        chk("samecyc_old_data", d, 3);
        chk("samecyc_old_miss", ms, 0);
        lookup(1, 0, 0, 1'b0, 0, 0, 0, d, ch, ms, lat);
        chk("samecyc_new_data", d, 7);

        // Back-to-back throughput with rsp_ready held high.
        exp_q = '{1, 6, 1, 6, 1, 6};
        rdy_ok = 0; rsp_n = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    if (k > 0) @(negedge clk);
                    req_valid = 1'b1; req_idx = 3'd2; req_mode = 1'b0; req_choice = 1'(k % 2);
                    if (req_ready) rdy_ok++;
                    @(posedge clk);
                end
                @(negedge clk);
                req_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 14; cyc++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        if (rsp_n < 6) chk($sformatf("stream_data%0d", rsp_n), int'(rsp_data), exp_q[rsp_n]);
                        rsp_n++;
                    end
                end
            end
        join
        chk("stream_ready_cycles", rdy_ok, 6);
        chk("stream_rsp_count", rsp_n, 6);

        // Back-pressure: exactly RSP_DEPTH accepted, then in-order drain.
        bp_idx = '{2, 2, 3, 5, 1};
        bp_ch  = '{0, 1, 1, 1, 0};
        exp_q  = '{1, 6, 5, 2, 0, 0};
        acc_n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_valid = (acc_n < 5);
            req_idx = 3'(bp_idx[acc_n < 5 ? acc_n : 4]);
            req_mode = 1'b0;
            req_choice = 1'(bp_ch[acc_n < 5 ? acc_n : 4]);
            acc = req_valid && req_ready;
            @(posedge clk);
            if (acc) acc_n++;
        end
        @(negedge clk);
        chk("bp_accepted", acc_n, 4);
        chk("bp_req_ready_low", int'(req_ready), 0);
        chk("bp_rsp_valid", int'(rsp_valid), 1);
        chk("bp_stall_data", int'(rsp_data), 1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rsp_n = 0;
        for (int cyc = 0; cyc < 20 && rsp_n < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("bp_drain%0d", rsp_n), int'(rsp_data), exp_q[rsp_n]);
                rsp_n++;
            end
        end
        chk("bp_drain_count", rsp_n, 4);
        @(negedge clk);
        chk("bp_req_ready_back", int'(req_ready), 1);
        chk("bp_empty", int'(rsp_valid), 0);

        // Reset with three responses queued.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_idx = 3'd2; req_mode = 1'b0; req_choice = 1'(k % 2);
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstq_rsp_valid_before", int'(rsp_valid), 1);
        chk("rstq_miss_count_before", int'(miss_count), 3);
        #2 rst = 1'b1;
        #1;
        chk("rstq_rsp_valid", int'(rsp_valid), 0);
        chk("rstq_req_ready", int'(req_ready), 0);
        chk("rstq_rsp_data", int'(rsp_data), 0);
        chk("rstq_miss_count", int'(miss_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstq_ready_after", int'(req_ready), 1);
        rsp_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("rstq_no_stale", stale, 0);
        lookup(2, 0, 0, 1'b0, 0, 0, 0, d, ch, ms, lat);
        chk("rstq_lk1_miss", ms, 1);
        chk("rstq_lk1_data", d, 0);
        lookup(3, 0, 1, 1'b0, 0, 0, 0, d, ch, ms, lat);
        chk("rstq_lk2_miss", ms, 1);
        @(negedge clk);
        chk("rstq_miss_count_after", int'(miss_count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
